// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared types for the PLL reset sequencer.
//   seq_state_t : sequencer state, with a fixed encoding because the value is
//                 exported on the `state` debug/LED port.
// ---------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } seq_state_t;

    localparam int LOSS_W = 8;

endpackage : pll_seq_pkg

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Generic two-flop synchroniser for a single-bit level signal.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops reset to 0
//   d     : asynchronous input
//   q     : synchronised output, two destination-clock cycles of latency
// ---------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : sync2

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
// Brings up the system PLL from the raw 50 MHz board clock: pulses PLL RST,
// waits for LOCKED, holds the downstream reset until lock has been stable for
// a settle interval, re-sequences on lock loss or request, and gives up into a
// sticky FAULT state after a bounded number of failed attempts. Everything runs
// on clk50 because the PLL output clock is meaningless before lock.
// Ports:
//   clk50      : 50 MHz board clock (only clock)
//   rstN       : asynchronous active-low reset
//   pllLocked  : PLL LOCKED, asynchronous to clk50
//   restartReq : single-cycle pulse forcing a full re-sequence
//   pllRst     : to PLL RST (registered)
//   sysRstN    : active-low downstream reset (registered); the consumer must
//                re-synchronise it into its own clock domain
//   ready      : high in RUN
//   fault      : high in FAULT
//   state      : encoded current state (debug / LEDs)
//   lossCnt    : lock losses seen while in RUN, saturating at 255
// ---------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 50_000,
    parameter int SETTLE       = 5_000,
    parameter int MAX_RETRIES  = 3,
    parameter int TW           = $clog2(
        (((RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT) > SETTLE
            ? ((RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT)
            : SETTLE) + 1)
) (
    input  logic              clk50,
    input  logic              rstN,
    input  logic              pllLocked,
    input  logic              restartReq,
    output logic              pllRst,
    output logic              sysRstN,
    output logic              ready,
    output logic              fault,
    output logic [2:0]        state,
    output logic [LOSS_W-1:0] lossCnt
);

    // Attempt counter only needs to reach MAX_RETRIES-1.
    localparam int AW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_HOLD - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [AW-1:0] ATT_LAST    = AW'(MAX_RETRIES - 1);

    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
    endfunction

    // Synchronised lock; every decision below uses lk, never pllLocked.
    logic lk;

    sync2 u_lock_sync (
        .clk   (clk50),
        .rst_n (rstN),
        .d     (pllLocked),
        .q     (lk)
    );

    seq_state_t        state_q,     state_d;
    logic [TW-1:0]     timer_q,     timer_d;
    logic [AW-1:0]     attempt_q,   attempt_d;
    logic [LOSS_W-1:0] loss_cnt_q,  loss_cnt_d;
    logic              pll_rst_q,   pll_rst_d;
    logic              sys_rst_n_q, sys_rst_n_d;
    logic              ready_q,     ready_d;
    logic              fault_q,     fault_d;

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs so they change on
    // exactly the same edge as the state).
    // ------------------------------------------------------------------
    always_ff @(posedge clk50 or negedge rstN) begin
        if (!rstN) begin
            state_q     <= S_RESET_PLL;
            timer_q     <= '0;
            attempt_q   <= '0;
            loss_cnt_q  <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            attempt_q   <= attempt_d;
            loss_cnt_q  <= loss_cnt_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Each state tests its limit before incrementing, so
    // the timer never wraps; every transition clears the timer.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        attempt_d  = attempt_q;
        loss_cnt_d = loss_cnt_q;

        if (restartReq) begin
            // Overrides every other transition; not counted as a lock loss.
            state_d   = S_RESET_PLL;
            timer_d   = '0;
            attempt_d = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (timer_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end

                S_WAIT_LOCK: begin
                    if (lk) begin
                        state_d = S_SETTLE;
                        timer_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        timer_d = '0;
                        if (attempt_q == ATT_LAST) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d   = S_RESET_PLL;
                            attempt_d = attempt_q + AW'(1);
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end

                S_SETTLE: begin
                    // A drop restarts the lock wait without spending an attempt.
                    if (!lk) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_d   = S_RUN;
                        timer_d   = '0;
                        attempt_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end

                S_RUN: begin
                    if (!lk) begin
                        state_d    = S_RESET_PLL;
                        timer_d    = '0;
                        attempt_d  = '0;
                        loss_cnt_d = sat_inc(loss_cnt_q);
                    end
                end

                S_FAULT: begin
                    // Sticky: only rstN or restartReq leave.
                end

                default: begin
                    state_d = S_RESET_PLL;
                    timer_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, registered above, so no decode
    // glitches reach the PLL or the reset tree.
    // ------------------------------------------------------------------
    always_comb begin
        pll_rst_d   = 1'b1;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        case (state_d)
            S_RESET_PLL: begin
                pll_rst_d = 1'b1;
            end
            S_WAIT_LOCK, S_SETTLE: begin
                pll_rst_d = 1'b0;
            end
            S_RUN: begin
                pll_rst_d   = 1'b0;
                sys_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            S_FAULT: begin
                // Keep the PLL parked in reset while faulted.
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b1;
            end
        endcase
    end

    assign pllRst  = pll_rst_q;
    assign sysRstN = sys_rst_n_q;
    assign ready   = ready_q;
    assign fault   = fault_q;
    assign state   = state_q;
    assign lossCnt = loss_cnt_q;

endmodule : pll_reset_sequencer
